// File: rtl/modulator_pkg.sv
// Shared types and constants for the PWM modulator frequency-select controller.
package modulator_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int              DIV_W            = 32;
  localparam logic [DIV_W-1:0] DIV_HIGH        = 32'd110592;
  localparam logic [DIV_W-1:0] DIV_LOW         = 32'd389120;
  localparam logic [23:0]      DEBOUNCE_DEFAULT = 24'd1000000;
  localparam logic [31:0]      TIMEOUT_DEFAULT  = 32'd50000000;

endpackage

// File: rtl/modulator_debounce_sync.sv
// Two-flop synchroniser for the raw switch followed by a hold-time debouncer.
module modulator_debounce_sync
  import modulator_pkg::*;
#(
  parameter logic [23:0] debounce_cycles_p = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic stable_o
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic [23:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      // Any return to the accepted level restarts the hold window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == debounce_cycles_p - 24'd1) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 24'd1;
      end
    end
  end

  assign stable_o = r_stable;

endmodule

// File: rtl/modulator_freq_ctrl.sv
// Frequency-select controller: commits a debounced switch change to the modulator
// only at a sample-period boundary, with a watchdog forcing the commit if none arrives.
module modulator_freq_ctrl
  import modulator_pkg::*;
#(
  parameter logic [23:0] debounce_cycles_p = DEBOUNCE_DEFAULT,
  parameter logic [31:0] timeout_cycles_p  = TIMEOUT_DEFAULT,
  parameter int          div_w_p           = DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_in,
  input  logic [div_w_p-1:0] div_high_i,
  input  logic [div_w_p-1:0] div_low_i,
  input  logic               period_end_i,
  output logic               sel_o,
  output logic [div_w_p-1:0] div_o,
  output logic               pending_o,
  output logic               change_o,
  output logic               forced_o
);

  state_t             r_state;
  logic               r_sel;
  logic [div_w_p-1:0] r_div;
  logic               r_change;
  logic               r_forced;
  logic [31:0]        r_tcnt;

  state_t             w_state_next;
  logic               w_stable;
  logic               w_commit;
  logic               w_force_set;
  logic               w_sel_next;
  logic [31:0]        w_tcnt_next;

  modulator_debounce_sync #(
    .debounce_cycles_p(debounce_cycles_p)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .stable_o(w_stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_force_set  = 1'b0;
    w_tcnt_next  = r_tcnt;
    case (r_state)
      IDLE: begin
        if (w_stable != r_sel) begin
          w_state_next = PENDING;
          w_tcnt_next  = '0;
        end
      end
      PENDING: begin
        if (r_tcnt != '1) begin
          w_tcnt_next = r_tcnt + 32'd1;
        end
        // Bounce-back outranks a boundary, which outranks the watchdog.
        if (w_stable == r_sel) begin
          w_state_next = IDLE;
        end else if (period_end_i) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end else if (r_tcnt == timeout_cycles_p - 32'd1) begin
          w_commit     = 1'b1;
          w_force_set  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_sel_next = w_commit ? w_stable : r_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= 1'b0;
      r_div    <= '0;
      r_change <= 1'b0;
      r_forced <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_sel    <= w_sel_next;
      r_div    <= w_sel_next ? div_high_i : div_low_i;
      r_change <= w_commit;
      r_forced <= r_forced | w_force_set;
      r_tcnt   <= w_tcnt_next;
    end
  end

  assign sel_o     = r_sel;
  assign div_o     = r_div;
  assign pending_o = (r_state == PENDING);
  assign change_o  = r_change;
  assign forced_o  = r_forced;

endmodule
